// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master.
// Provides the FSM state encoding, the AXI response codes, the default
// protection value and a helper that classifies a response as an error.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR are the two codes with resp[1] set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master.
// Turns one CPU request (req/wr/addr/wdata/wstrb) into one AXI4-Lite write
// (AW+W+B) or read (AR+R) and reports completion with a one-cycle cpu_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_*               CPU side: request in, rdata/ready/error out
//   M_AXI_AW*/W*/B*     AXI4-Lite write address, write data, write response
//   M_AXI_AR*/R*        AXI4-Lite read address, read data
// All outputs are registered except BREADY/RREADY, which decode the state.
module axi4_lite_master
  import axi4_lite_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_error,

  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,

  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,

  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,

  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,

  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  state_t st, st_nxt;
  logic   accept;
  logic   aw_pend_nxt, w_pend_nxt;

  assign M_AXI_AWPROT = PROT_DEFAULT;
  assign M_AXI_ARPROT = PROT_DEFAULT;
  assign M_AXI_BREADY = (st == WR_RESP);
  assign M_AXI_RREADY = (st == RD_DATA);

  // A channel is still pending after this edge if its VALID is up and the
  // slave has not taken it; AW and W may finish on different edges.
  assign aw_pend_nxt = M_AXI_AWVALID & ~M_AXI_AWREADY;
  assign w_pend_nxt  = M_AXI_WVALID  & ~M_AXI_WREADY;

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    accept = 1'b0;
    case (st)
      IDLE: if (cpu_req) begin
        accept = 1'b1;
        st_nxt = cpu_wr ? WR_REQ : RD_REQ;
      end
      WR_REQ:  if (!aw_pend_nxt && !w_pend_nxt) st_nxt = WR_RESP;
      WR_RESP: if (M_AXI_BVALID)                st_nxt = IDLE;
      RD_REQ:  if (M_AXI_ARREADY)               st_nxt = RD_DATA;
      RD_DATA: if (M_AXI_RVALID)                st_nxt = IDLE;
      default:                                  st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata     <= '0;
      cpu_ready     <= 1'b0;
      cpu_error     <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      // Each VALID drops on its own handshake edge; address/data regs are
      // untouched so they stay stable for the whole VALID window.
      if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
      if (M_AXI_WVALID  && M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) M_AXI_ARVALID <= 1'b0;
      case (st)
        IDLE: if (accept) begin
          cpu_error <= 1'b0;
          if (cpu_wr) begin
            M_AXI_AWADDR  <= cpu_addr;
            M_AXI_WDATA   <= cpu_wdata;
            M_AXI_WSTRB   <= cpu_wstrb;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
          end else begin
            M_AXI_ARADDR  <= cpu_addr;
            M_AXI_ARVALID <= 1'b1;
          end
        end
        WR_RESP: if (M_AXI_BVALID) begin
          cpu_ready <= 1'b1;
          cpu_error <= resp_is_err(M_AXI_BRESP);
        end
        RD_DATA: if (M_AXI_RVALID) begin
          cpu_ready <= 1'b1;
          cpu_rdata <= M_AXI_RDATA;
          cpu_error <= resp_is_err(M_AXI_RRESP);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a memory-backed AXI4-Lite slave with per-channel
// READY delays and response injection, plus scoreboards for AW/W/AR beats and
// for CPU completions (rdata, error).
module tb_axi4_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_error;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
  logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;
  logic [31:0] M_AXI_RDATA = '0;

  always #5 clk = ~clk;

  axi4_lite_master dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_error(cpu_error),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] aw_q[$], ar_q[$];
  logic [35:0] w_q[$];
  logic [31:0] last_rd = '0;

  // slave knobs
  int         aw_delay = 1, w_delay = 1, ar_delay = 1;
  bit         eager_aw = 0, eager_w = 0, eager_ar = 0;
  logic [1:0] nxt_bresp = 2'b00, nxt_rresp = 2'b00;

  // slave state
  logic [31:0] mem [0:255];
  int          aw_wait, w_wait, ar_wait;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, rdy_cnt = 0;
  bit          aw_hs, w_hs, ar_hs, b_hs, r_hs, got_aw, got_w, wr_ph, rd_ph;
  bit          prev_rdy, prev_awv, prev_wv, prev_arv;
  logic [31:0] prev_awaddr, prev_araddr, cap_awaddr, cap_araddr, cap_wdata, sb_a;
  logic [35:0] prev_w, sb_w;
  logic [3:0]  cap_wstrb;

  // Slave runs 2 time units after each rising edge. A handshake seen here
  // (VALID & READY) completes on the next rising edge; its consequences are
  // applied at the following tick.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
      M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
      got_aw = 0; got_w = 0; wr_ph = 0; rd_ph = 0;
      prev_rdy = 0; prev_awv = 0; prev_wv = 0; prev_arv = 0;
      aw_wait = aw_delay; w_wait = w_delay; ar_wait = ar_delay;
    end else begin
      if (aw_hs) begin
        M_AXI_AWREADY = 0; got_aw = 1; total++;
        if (M_AXI_AWVALID !== 1'b0) begin bad++; $display("FAIL awvalid_drop got=%b want=0", M_AXI_AWVALID); end
      end
      if (w_hs) begin
        M_AXI_WREADY = 0; got_w = 1; total++;
        if (M_AXI_WVALID !== 1'b0) begin bad++; $display("FAIL wvalid_drop got=%b want=0", M_AXI_WVALID); end
      end
      if (ar_hs) begin
        M_AXI_ARREADY = 0; total++;
        if (M_AXI_ARVALID !== 1'b0) begin bad++; $display("FAIL arvalid_drop got=%b want=0", M_AXI_ARVALID); end
        M_AXI_RVALID = 1; M_AXI_RDATA = mem[cap_araddr[9:2]]; M_AXI_RRESP = nxt_rresp; rd_ph = 1;
      end
      if (b_hs) begin M_AXI_BVALID = 0; wr_ph = 0; end
      if (r_hs) begin M_AXI_RVALID = 0; rd_ph = 0; end
      if (got_aw && got_w) begin
        for (int b = 0; b < 4; b++)
          if (cap_wstrb[b]) mem[cap_awaddr[9:2]][8*b +: 8] = cap_wdata[8*b +: 8];
        M_AXI_BVALID = 1; M_AXI_BRESP = nxt_bresp; wr_ph = 1; got_aw = 0; got_w = 0;
      end

      // BREADY/RREADY must be high exactly while a response is owed.
      total++;
      if (M_AXI_BREADY !== wr_ph || M_AXI_RREADY !== rd_ph) begin
        bad++;
        $display("FAIL resp_ready bready=%b rready=%b want %b %b", M_AXI_BREADY, M_AXI_RREADY, wr_ph, rd_ph);
      end
      if (cpu_ready === 1'b1) begin
        rdy_cnt++; total++;
        if (prev_rdy) begin bad++; $display("FAIL ready_width cpu_ready high 2 cycles, want 1"); end
      end
      prev_rdy = (cpu_ready === 1'b1);

      // payload must hold while VALID stays up
      if (M_AXI_AWVALID && prev_awv) begin
        total++;
        if (M_AXI_AWADDR !== prev_awaddr) begin bad++; $display("FAIL awaddr_stable got=%h want=%h", M_AXI_AWADDR, prev_awaddr); end
      end
      if (M_AXI_WVALID && prev_wv) begin
        total++;
        if ({M_AXI_WSTRB, M_AXI_WDATA} !== prev_w) begin bad++; $display("FAIL w_stable got=%h want=%h", {M_AXI_WSTRB, M_AXI_WDATA}, prev_w); end
      end
      if (M_AXI_ARVALID && prev_arv) begin
        total++;
        if (M_AXI_ARADDR !== prev_araddr) begin bad++; $display("FAIL araddr_stable got=%h want=%h", M_AXI_ARADDR, prev_araddr); end
      end
      prev_awv = M_AXI_AWVALID; prev_awaddr = M_AXI_AWADDR;
      prev_wv = M_AXI_WVALID;   prev_w = {M_AXI_WSTRB, M_AXI_WDATA};
      prev_arv = M_AXI_ARVALID; prev_araddr = M_AXI_ARADDR;

      // READY generation: delay counts ticks with VALID seen, or eager (always high)
      if (!M_AXI_AWVALID) aw_wait = aw_delay;
      if (!M_AXI_WVALID)  w_wait  = w_delay;
      if (!M_AXI_ARVALID) ar_wait = ar_delay;
      if (eager_aw) M_AXI_AWREADY = 1;
      else if (M_AXI_AWVALID && !M_AXI_AWREADY) begin if (aw_wait > 0) aw_wait--; else M_AXI_AWREADY = 1; end
      if (eager_w) M_AXI_WREADY = 1;
      else if (M_AXI_WVALID && !M_AXI_WREADY) begin if (w_wait > 0) w_wait--; else M_AXI_WREADY = 1; end
      if (eager_ar) M_AXI_ARREADY = 1;
      else if (M_AXI_ARVALID && !M_AXI_ARREADY) begin if (ar_wait > 0) ar_wait--; else M_AXI_ARREADY = 1; end

      // handshakes for the upcoming edge, scored against expectations
      aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
      w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
      ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
      b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
      r_hs  = M_AXI_RVALID  && M_AXI_RREADY;
      if (aw_hs) begin
        cap_awaddr = M_AXI_AWADDR; aw_cnt++; total++;
        if (aw_q.size() == 0) begin bad++; $display("FAIL aw_unexpected addr=%h want none", M_AXI_AWADDR); end
        else begin
          sb_a = aw_q.pop_front();
          if (M_AXI_AWADDR !== sb_a) begin bad++; $display("FAIL awaddr got=%h want=%h", M_AXI_AWADDR, sb_a); end
        end
      end
      if (w_hs) begin
        cap_wdata = M_AXI_WDATA; cap_wstrb = M_AXI_WSTRB; w_cnt++; total++;
        if (w_q.size() == 0) begin bad++; $display("FAIL w_unexpected data=%h want none", M_AXI_WDATA); end
        else begin
          sb_w = w_q.pop_front();
          if ({M_AXI_WSTRB, M_AXI_WDATA} !== sb_w) begin bad++; $display("FAIL wbeat got=%h want=%h", {M_AXI_WSTRB, M_AXI_WDATA}, sb_w); end
        end
      end
      if (ar_hs) begin
        cap_araddr = M_AXI_ARADDR; ar_cnt++; total++;
        if (ar_q.size() == 0) begin bad++; $display("FAIL ar_unexpected addr=%h want none", M_AXI_ARADDR); end
        else begin
          sb_a = ar_q.pop_front();
          if (M_AXI_ARADDR !== sb_a) begin bad++; $display("FAIL araddr got=%h want=%h", M_AXI_ARADDR, sb_a); end
        end
      end
    end
  end

  // Drive one request at the current falling edge; expectations are queued now.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_wr = wr; cpu_req = 1'b1;
    if (wr) begin aw_q.push_back(a); w_q.push_back({s, d}); end
    else ar_q.push_back(a);
    e.rdata = wr ? last_rd : exp_rd;
    e.err   = exp_err;
    exp_q.push_back(e);
    if (!wr) last_rd = exp_rd;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  // Wait (bounded) for cpu_ready and score the completion; returns in that cycle.
  task automatic wait_done(input string nm);
    exp_t e;
    int   n = 0;
    while (cpu_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++; $display("FAIL %s timeout cpu_ready=%b want=1", nm, cpu_ready);
    end else if (cpu_rdata !== e.rdata || cpu_error !== e.err) begin
      bad++; $display("FAIL %s rdata=%h err=%b want %h %b", nm, cpu_rdata, cpu_error, e.rdata, e.err);
    end
  endtask

  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err, input string nm);
    issue(wr, a, d, s, exp_rd, exp_err);
    wait_done(nm);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, cpu_ready, cpu_error} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, cpu_ready, cpu_error});
    end
    total++;
    if ({cpu_rdata, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR} !== '0) begin
      bad++; $display("FAIL reset_data rdata=%h aw=%h w=%h s=%h ar=%h want 0", cpu_rdata, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR);
    end
    total++;
    if ({M_AXI_AWPROT, M_AXI_ARPROT} !== 6'b0) begin bad++; $display("FAIL prot got=%b want=0", {M_AXI_AWPROT, M_AXI_ARPROT}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int aw0 = aw_cnt, w0 = w_cnt, ar0 = ar_cnt, r0 = rdy_cnt;
    // first write also pins the cycle-level latency
    issue(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, '0, 1'b0);
    total++;
    if (!(M_AXI_AWVALID === 1'b1 && M_AXI_WVALID === 1'b1)) begin bad++; $display("FAIL valid_rise aw=%b w=%b want 1 1", M_AXI_AWVALID, M_AXI_WVALID); end
    repeat (2) @(negedge clk);
    total++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, cpu_ready} !== 3'b000) begin bad++; $display("FAIL valid_drop got=%b want=000", {M_AXI_AWVALID, M_AXI_WVALID, cpu_ready}); end
    @(negedge clk);
    total++;
    if (cpu_ready !== 1'b1) begin bad++; $display("FAIL ready_latency cpu_ready=%b want=1", cpu_ready); end
    wait_done("wr0");
    xact(1'b1, 32'h4, 32'h1234_5678, 4'hF, '0, 1'b0, "wr4");
    xact(1'b0, 32'h0, '0, '0, 32'hDEAD_BEEF, 1'b0, "rd0");
    xact(1'b0, 32'h4, '0, '0, 32'h1234_5678, 1'b0, "rd4");
    total++;
    if (aw_cnt - aw0 != 2 || w_cnt - w0 != 2 || ar_cnt - ar0 != 2 || rdy_cnt - r0 != 4) begin
      bad++; $display("FAIL wr_rd_counts aw=%0d w=%0d ar=%0d rdy=%0d want 2 2 2 4", aw_cnt - aw0, w_cnt - w0, ar_cnt - ar0, rdy_cnt - r0);
    end
  endtask

  task automatic test_strobes();
    xact(1'b1, 32'h20, 32'h0000_0000, 4'hF, '0, 1'b0, "strbF");
    xact(1'b1, 32'h20, 32'h0000_00FF, 4'h1, '0, 1'b0, "strb1");
    xact(1'b1, 32'h20, 32'h0000_FF00, 4'h2, '0, 1'b0, "strb2");
    xact(1'b0, 32'h20, '0, '0, 32'h0000_FFFF, 1'b0, "strb_rd");
  endtask

  task automatic test_back_to_back();
    int aw0 = aw_cnt, r0 = rdy_cnt;
    eager_aw = 1; eager_w = 1; eager_ar = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) xact(1'b1, 32'h100 + 4*i, i, 4'hF, '0, 1'b0, "b2b_wr");
    for (int i = 0; i < 8; i++) xact(1'b0, 32'h100 + 4*i, '0, '0, i, 1'b0, "b2b_rd");
    total++;
    if (aw_cnt - aw0 != 8 || rdy_cnt - r0 != 16) begin
      bad++; $display("FAIL b2b_counts aw=%0d rdy=%0d want 8 16", aw_cnt - aw0, rdy_cnt - r0);
    end
    @(negedge clk);
    eager_aw = 0; eager_w = 0; eager_ar = 0;
    @(negedge clk);
  endtask

  task automatic test_errors();
    nxt_bresp = 2'b10;
    xact(1'b1, 32'h8, 32'h0000_0055, 4'hF, '0, 1'b1, "slverr_wr");
    repeat (3) @(negedge clk);
    total++;
    if (cpu_error !== 1'b1) begin bad++; $display("FAIL err_hold cpu_error=%b want=1", cpu_error); end
    nxt_bresp = 2'b00; nxt_rresp = 2'b11;
    xact(1'b0, 32'h8, '0, '0, 32'h0000_0055, 1'b1, "decerr_rd");
    nxt_rresp = 2'b00;
    issue(1'b0, 32'h8, '0, '0, 32'h0000_0055, 1'b0);
    total++;
    if (cpu_error !== 1'b0) begin bad++; $display("FAIL err_clear_at_accept cpu_error=%b want=0", cpu_error); end
    wait_done("okay_rd");
  endtask

  task automatic test_stall_and_reset();
    int r0;
    // AW held off while W goes through at once
    aw_delay = 6; eager_w = 1;
    @(negedge clk);
    issue(1'b1, 32'h40, 32'hA5A5_0001, 4'hF, '0, 1'b0);
    @(negedge clk);
    total++;
    if (!(M_AXI_AWVALID === 1'b1 && M_AXI_WVALID === 1'b0 && M_AXI_AWADDR === 32'h40)) begin
      bad++; $display("FAIL stall_w_alone aw=%b w=%b addr=%h want 1 0 00000040", M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR);
    end
    wait_done("stall_wr");
    // abort in WR_REQ with AW stalled
    aw_delay = 20;
    @(negedge clk);
    issue(1'b1, 32'h80, 32'hCAFE_0002, 4'hF, '0, 1'b0);
    @(negedge clk);
    total++;
    if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b10) begin bad++; $display("FAIL pre_reset aw/w=%b want 10", {M_AXI_AWVALID, M_AXI_WVALID}); end
    r0 = rdy_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, cpu_ready, cpu_rdata} !== '0) begin
      bad++; $display("FAIL abort_state valids=%b rdy=%b rdata=%h want 0", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, cpu_ready, cpu_rdata);
    end
    aw_q.delete(); exp_q.delete(); last_rd = '0;
    aw_delay = 1; eager_w = 0;
    repeat (10) @(negedge clk);
    total++;
    if (rdy_cnt != r0 || M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0) begin
      bad++; $display("FAIL abort_no_ready rdy=%0d aw=%b w=%b want %0d 0 0", rdy_cnt, M_AXI_AWVALID, M_AXI_WVALID, r0);
    end
    // block is usable again after the abort
    xact(1'b0, 32'h40, '0, '0, 32'hA5A5_0001, 1'b0, "post_abort_rd");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_strobes();
    test_back_to_back();
    test_errors();
    test_stall_and_reset();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded, want completion");
    $fatal(1, "timeout");
  end

endmodule
